// File: rtl/sha3_pkg.sv
// Shared constants, padding bytes and loader state encoding for the SHA3-256 front end.
package sha3_pkg;

  localparam int unsigned RATE_BYTES = 136;
  localparam int unsigned CHUNK_BITS = 136;
  localparam int unsigned NUM_CHUNKS = RATE_BYTES * 8 / CHUNK_BITS;
  localparam int unsigned BUF_BITS   = RATE_BYTES * 8;
  localparam int unsigned CNT_W      = 8;
  localparam int unsigned IDX_W      = 3;
  localparam int unsigned POS_W      = 11;

  localparam logic [7:0] PAD_DOMAIN = 8'h06;
  localparam logic [7:0] PAD_FINAL  = 8'h80;

  typedef enum logic [2:0] {
    FILL,
    PAD,
    EMIT,
    START,
    WAIT
  } state_t;

endpackage

// File: rtl/sha3_pad_loader.sv
// Byte-stream to SHA3-256 rate-block loader: packs bytes MSB-first, applies 0x06..0x80
// padding, streams eight scan beats, pulses core_start and waits for the core.
module sha3_pad_loader
  import sha3_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0]            in_data,
  input  logic                  in_keep,
  input  logic                  in_last,
  output logic [CHUNK_BITS-1:0] scan_in,
  output logic                  scan_valid,
  output logic                  block_last,
  output logic                  core_start,
  input  logic                  core_done,
  output logic                  msg_done
);

  state_t                r_state;
  logic [BUF_BITS-1:0]   r_buf;
  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_final;
  logic                  r_pending_pad;
  logic                  r_in_ready;
  logic [CHUNK_BITS-1:0] r_scan_in;
  logic                  r_scan_valid;
  logic                  r_block_last;
  logic                  r_core_start;
  logic                  r_msg_done;

  logic [POS_W-1:0]      w_byte_lsb;
  logic [POS_W-1:0]      w_beat_lsb;
  logic [BUF_BITS-1:0]   w_wr_buf;
  logic [BUF_BITS-1:0]   w_pad_buf;
  logic [CHUNK_BITS-1:0] w_beat;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic                  w_full;

  // Byte k lives at bits [1087-8k -: 8]; the buffer is zero before filling, so OR acts as write.
  assign w_byte_lsb = POS_W'(BUF_BITS - 8) - {r_cnt, 3'b000};
  assign w_wr_buf   = r_buf | (BUF_BITS'(in_data) << w_byte_lsb);
  assign w_pad_buf  = r_buf | (BUF_BITS'(PAD_DOMAIN) << w_byte_lsb) | BUF_BITS'(PAD_FINAL);
  assign w_beat_lsb = POS_W'(r_idx) * POS_W'(CHUNK_BITS);
  assign w_beat     = CHUNK_BITS'(r_buf >> w_beat_lsb);
  assign w_cnt_nxt  = r_cnt + CNT_W'(1);
  assign w_full     = (w_cnt_nxt == CNT_W'(RATE_BYTES));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= FILL;
      r_buf         <= '0;
      r_cnt         <= '0;
      r_idx         <= '0;
      r_final       <= 1'b0;
      r_pending_pad <= 1'b0;
      r_in_ready    <= 1'b0;
      r_scan_in     <= '0;
      r_scan_valid  <= 1'b0;
      r_block_last  <= 1'b0;
      r_core_start  <= 1'b0;
      r_msg_done    <= 1'b0;
    end else begin
      r_scan_in    <= '0;
      r_scan_valid <= 1'b0;
      r_block_last <= 1'b0;
      r_core_start <= 1'b0;
      r_msg_done   <= 1'b0;
      case (r_state)
        FILL: begin
          r_in_ready <= 1'b1;
          if (r_in_ready && in_valid) begin
            if (in_keep) begin
              r_buf <= w_wr_buf;
              r_cnt <= w_cnt_nxt;
              if (w_full) begin
                // A full block ending the message still owes a padding-only block.
                r_state       <= EMIT;
                r_idx         <= '0;
                r_pending_pad <= in_last;
                r_in_ready    <= 1'b0;
              end else if (in_last) begin
                r_state    <= PAD;
                r_in_ready <= 1'b0;
              end
            end else if (in_last) begin
              r_state    <= PAD;
              r_in_ready <= 1'b0;
            end
          end
        end
        PAD: begin
          r_buf   <= w_pad_buf;
          r_final <= 1'b1;
          r_idx   <= '0;
          r_state <= EMIT;
        end
        EMIT: begin
          r_scan_valid <= 1'b1;
          r_scan_in    <= w_beat;
          r_block_last <= r_final;
          r_idx        <= r_idx + IDX_W'(1);
          if (r_idx == IDX_W'(NUM_CHUNKS - 1)) r_state <= START;
        end
        START: begin
          r_core_start <= 1'b1;
          r_block_last <= r_final;
          r_state      <= WAIT;
        end
        WAIT: begin
          if (core_done) begin
            r_buf <= '0;
            r_cnt <= '0;
            if (r_pending_pad) begin
              r_pending_pad <= 1'b0;
              r_state       <= PAD;
            end else begin
              r_state    <= FILL;
              r_in_ready <= 1'b1;
              r_msg_done <= r_final;
              r_final    <= 1'b0;
            end
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign scan_in    = r_scan_in;
  assign scan_valid = r_scan_valid;
  assign block_last = r_block_last;
  assign core_start = r_core_start;
  assign msg_done   = r_msg_done;

endmodule

// File: tb/tb_sha3_pad_loader.sv
// Directed bench for sha3_pad_loader: padded, empty, 135/136-byte, spurious-input and reset cases.
module tb_sha3_pad_loader;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic         in_keep;
  logic         in_last;
  logic [135:0] scan_in;
  logic         scan_valid;
  logic         block_last;
  logic         core_start;
  logic         core_done;
  logic         msg_done;

  logic [7:0]    msg [0:135];
  logic [1087:0] blk;
  int            n_checks;
  int            n_errors;

  sha3_pad_loader dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_keep   (in_keep),
    .in_last   (in_last),
    .scan_in   (scan_in),
    .scan_valid(scan_valid),
    .block_last(block_last),
    .core_start(core_start),
    .core_done (core_done),
    .msg_done  (msg_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [135:0] got, input logic [135:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference block: message bytes MSB-first, optional 0x06/0x80 padding.
  task automatic build_block(input int len, input bit pad, output logic [1087:0] b);
    b = '0;
    for (int k = 0; k < len; k++) b[1087 - 8*k -: 8] = msg[k];
    if (pad) begin
      b[1087 - 8*len -: 8] = b[1087 - 8*len -: 8] | 8'h06;
      b[7:0] = b[7:0] | 8'h80;
    end
  endtask

  task automatic send_msg(input int len, input bit hold_valid);
    if (len == 0) begin
      in_valid = 1'b1; in_keep = 1'b0; in_last = 1'b1; in_data = 8'h00;
      check("rdy_empty", 136'(in_ready), 136'(1'b1));
      step();
    end else begin
      for (int i = 0; i < len; i++) begin
        in_valid = 1'b1; in_keep = 1'b1; in_data = msg[i]; in_last = (i == len - 1);
        check($sformatf("rdy_byte%0d", i), 136'(in_ready), 136'(1'b1));
        step();
      end
    end
    in_last  = 1'b0;
    in_valid = hold_valid;
    in_keep  = hold_valid;
    in_data  = hold_valid ? 8'hAA : 8'h00;
  endtask

  task automatic collect_block(input logic [1087:0] b, input int exp_lat, input bit exp_last,
                               input int spurious_beat);
    int steps;
    steps = 0;
    while (scan_valid !== 1'b1 && steps < 40) begin
      step();
      steps++;
    end
    check("latency", 136'(steps), 136'(exp_lat));
    if (scan_valid !== 1'b1) return;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("beat%0d", i), scan_in, b[i*136 +: 136]);
      check($sformatf("blast_beat%0d", i), 136'(block_last), 136'(exp_last));
      check($sformatf("rdy_beat%0d", i), 136'(in_ready), 136'(1'b0));
      if (i == spurious_beat) core_done = 1'b1;
      step();
      core_done = 1'b0;
    end
    check("start_pulse", 136'(core_start), 136'(1'b1));
    check("start_valid", 136'(scan_valid), 136'(1'b0));
    check("start_scan_zero", scan_in, 136'(0));
    check("start_blast", 136'(block_last), 136'(exp_last));
    step();
    check("start_one_cycle", 136'(core_start), 136'(1'b0));
    check("wait_blast", 136'(block_last), 136'(1'b0));
  endtask

  task automatic done_pulse(input bit exp_msg_done, input bit exp_ready);
    for (int i = 0; i < 3; i++) begin
      check("wait_rdy", 136'(in_ready), 136'(1'b0));
      check("wait_no_done", 136'(msg_done), 136'(1'b0));
      step();
    end
    in_valid  = 1'b0;
    in_keep   = 1'b0;
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    check("msg_done", 136'(msg_done), 136'(exp_msg_done));
    check("rdy_after_done", 136'(in_ready), 136'(exp_ready));
    if (exp_msg_done) begin
      step();
      check("msg_done_pulse", 136'(msg_done), 136'(1'b0));
    end
  endtask

  task automatic load_awesome();
    string s;
    s = "18632ISAWESOME";
    for (int i = 0; i < 14; i++) msg[i] = s[i];
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_keep   = 1'b0;
    in_last   = 1'b0;
    in_data   = 8'h00;
    core_done = 1'b0;
    for (int i = 0; i < 136; i++) msg[i] = 8'h00;

    repeat (3) step();
    check("rst_in_ready", 136'(in_ready), 136'(1'b0));
    check("rst_scan_valid", 136'(scan_valid), 136'(1'b0));
    check("rst_scan_in", scan_in, 136'(0));
    check("rst_core_start", 136'(core_start), 136'(1'b0));
    check("rst_block_last", 136'(block_last), 136'(1'b0));
    check("rst_msg_done", 136'(msg_done), 136'(1'b0));
    reset = 1'b1;
    step();
    check("rdy_after_reset", 136'(in_ready), 136'(1'b1));

    // 14-byte message, in_valid held through EMIT/START/WAIT, spurious core_done in EMIT
    load_awesome();
    send_msg(14, 1'b1);
    blk = {136'h31383633324953415745534f4d45060000, 816'h0, 136'h80};
    collect_block(blk, 2, 1'b1, 2);
    done_pulse(1'b1, 1'b1);

    // Empty message
    send_msg(0, 1'b0);
    blk = {8'h06, 1072'h0, 8'h80};
    collect_block(blk, 2, 1'b1, -1);
    done_pulse(1'b1, 1'b1);

    // 135-byte message: last byte becomes 0x86
    for (int k = 0; k < 135; k++) msg[k] = 8'(k + 1);
    send_msg(135, 1'b0);
    build_block(135, 1'b1, blk);
    collect_block(blk, 2, 1'b1, -1);
    done_pulse(1'b1, 1'b1);

    // 136-byte message: unpadded block, then a padding-only block
    for (int k = 0; k < 136; k++) msg[k] = 8'(k) ^ 8'h5A;
    send_msg(136, 1'b0);
    build_block(136, 1'b0, blk);
    collect_block(blk, 1, 1'b0, -1);
    done_pulse(1'b0, 1'b0);
    blk = {8'h06, 1072'h0, 8'h80};
    collect_block(blk, 2, 1'b1, -1);
    done_pulse(1'b1, 1'b1);

    // Reset asserted after beat 3 of EMIT
    load_awesome();
    send_msg(14, 1'b0);
    for (int i = 0; i < 40 && scan_valid !== 1'b1; i++) step();
    check("pre_reset_valid", 136'(scan_valid), 136'(1'b1));
    repeat (3) step();
    reset = 1'b0;
    #1;
    check("midrst_scan_valid", 136'(scan_valid), 136'(1'b0));
    check("midrst_scan_in", scan_in, 136'(0));
    check("midrst_block_last", 136'(block_last), 136'(1'b0));
    check("midrst_core_start", 136'(core_start), 136'(1'b0));
    check("midrst_in_ready", 136'(in_ready), 136'(1'b0));
    check("midrst_msg_done", 136'(msg_done), 136'(1'b0));
    #2;
    reset = 1'b1;
    step();
    check("rdy_after_midrst", 136'(in_ready), 136'(1'b1));
    check("no_done_after_midrst", 136'(msg_done), 136'(1'b0));
    send_msg(14, 1'b0);
    blk = {136'h31383633324953415745534f4d45060000, 816'h0, 136'h80};
    collect_block(blk, 2, 1'b1, -1);
    done_pulse(1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
